// File: rtl/pc_unit.sv
// pc_unit: IF-stage program counter with exception vectoring, redirect,
// stall hold, return-address-stack prediction and sequential increment.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset (0 = in reset)
//   stall         hazard hold: pc and RAS keep their values
//   exc_req       exception request; pc <= EXC_VECTOR, epc <= exc_pc
//   exc_pc        PC of the faulting instruction
//   redirect      resolved taken branch/jump; pc <= redirect_pc
//   redirect_pc   redirect target
//   ras_push      call decoded; push ras_push_addr
//   ras_push_addr return address to push
//   ras_pop       return decoded; predict from top of stack
//   pc            current fetch address
//   pc_inc        pc + INC (combinational)
//   epc           last captured exception PC
//   ras_count     number of valid RAS entries
//   ras_hit       RAS prediction used this cycle (combinational)
module pc_unit #(
  parameter int unsigned                  ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]        RESET_VECTOR = ADDR_WIDTH'(32'h0000_0000),
  parameter logic [ADDR_WIDTH-1:0]        EXC_VECTOR   = ADDR_WIDTH'(32'h0000_0080),
  parameter int unsigned                  INC          = 4,
  parameter int unsigned                  RAS_DEPTH    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            stall,
  input  logic                            exc_req,
  input  logic [ADDR_WIDTH-1:0]           exc_pc,
  input  logic                            redirect,
  input  logic [ADDR_WIDTH-1:0]           redirect_pc,
  input  logic                            ras_push,
  input  logic [ADDR_WIDTH-1:0]           ras_push_addr,
  input  logic                            ras_pop,
  output logic [ADDR_WIDTH-1:0]           pc,
  output logic [ADDR_WIDTH-1:0]           pc_inc,
  output logic [ADDR_WIDTH-1:0]           epc,
  output logic [$clog2(RAS_DEPTH):0]      ras_count,
  output logic                            ras_hit
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] INC_W    = ADDR_WIDTH'(INC);

  typedef enum logic [2:0] {
    SEL_EXC,
    SEL_REDIRECT,
    SEL_HOLD,
    SEL_RAS,
    SEL_SEQ
  } pc_sel_e;

  pc_sel_e               sel;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] epc_q, epc_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_WIDTH-1:0] ras_d [RAS_DEPTH];

  logic [PTR_W-1:0]      top_idx;
  logic                  ras_empty;
  logic                  ras_active;
  logic [ADDR_WIDTH-1:0] pc_seq;

  assign top_idx   = ptr_q - PTR_ONE;
  assign ras_empty = (cnt_q == '0);
  assign pc_seq    = pc_q + INC_W;

  // Next-pc source selection, highest priority first.
  always_comb begin
    sel = SEL_SEQ;
    if (exc_req) begin
      sel = SEL_EXC;
    end else if (redirect) begin
      sel = SEL_REDIRECT;
    end else if (stall) begin
      sel = SEL_HOLD;
    end else if (ras_pop && !ras_empty) begin
      sel = SEL_RAS;
    end
  end

  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    unique case (sel)
      SEL_EXC: begin
        pc_d  = EXC_VECTOR;
        epc_d = exc_pc;
      end
      SEL_REDIRECT: pc_d = redirect_pc;
      SEL_HOLD:     pc_d = pc_q;
      SEL_RAS:      pc_d = ras_q[top_idx];
      SEL_SEQ:      pc_d = pc_seq;
      default:      pc_d = pc_seq;
    endcase
  end

  // RAS only moves when fetch is free-running (prediction or sequential).
  assign ras_active = (sel == SEL_RAS) || (sel == SEL_SEQ);

  always_comb begin
    ras_d = ras_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (ras_active) begin
      if ((sel == SEL_RAS) && ras_push) begin
        // Pop then push collapses to replacing the top in place.
        ras_d[top_idx] = ras_push_addr;
      end else if (sel == SEL_RAS) begin
        ptr_d = top_idx;
        cnt_d = cnt_q - CNT_ONE;
      end else if (ras_push) begin
        // When full, ptr_q points at the oldest entry, so it is overwritten.
        ras_d[ptr_q] = ras_push_addr;
        ptr_d        = ptr_q + PTR_ONE;
        cnt_d        = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= ras_d[i];
      end
    end
  end

  assign pc        = pc_q;
  assign pc_inc    = pc_seq;
  assign epc       = epc_q;
  assign ras_count = cnt_q;
  assign ras_hit   = (sel == SEL_RAS);

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RVEC  = 32'h0000_0000;
  localparam logic [31:0] EVEC  = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, exc_req, redirect, ras_push, ras_pop;
  logic [31:0] exc_pc, redirect_pc, ras_push_addr;
  logic [31:0] pc, pc_inc, epc;
  logic [2:0]  ras_count;
  logic        ras_hit;

  int checks = 0;
  int errors = 0;

  // Reference model: pc/epc as plain values, RAS as a bounded LIFO queue.
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic [31:0] m_ras [$];

  pc_unit #(
    .ADDR_WIDTH   (AW),
    .RESET_VECTOR (RVEC),
    .EXC_VECTOR   (EVEC),
    .INC          (4),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .exc_req       (exc_req),
    .exc_pc        (exc_pc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .ras_push      (ras_push),
    .ras_push_addr (ras_push_addr),
    .ras_pop       (ras_pop),
    .pc            (pc),
    .pc_inc        (pc_inc),
    .epc           (epc),
    .ras_count     (ras_count),
    .ras_hit       (ras_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = RVEC;
    m_epc = '0;
    m_ras.delete();
  endtask

  function automatic logic model_hit(input logic s, e, r, po);
    return !e && !r && !s && po && (m_ras.size() > 0);
  endfunction

  task automatic model_update(input logic s, e, input logic [31:0] ep, input logic r,
                              input logic [31:0] rp, input logic pu,
                              input logic [31:0] pa, input logic po);
    if (e) begin
      m_pc  = EVEC;
      m_epc = ep;
    end else if (r) begin
      m_pc = rp;
    end else if (s) begin
      m_pc = m_pc;
    end else if (po && m_ras.size() > 0) begin
      m_pc = m_ras[$];
      if (pu) m_ras[m_ras.size()-1] = pa;
      else    void'(m_ras.pop_back());
    end else begin
      m_pc = m_pc + 32'd4;
      if (pu) begin
        m_ras.push_back(pa);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pc"},        pc,             m_pc);
    check({tag, ".pc_inc"},    pc_inc,         m_pc + 32'd4);
    check({tag, ".epc"},       epc,            m_epc);
    check({tag, ".ras_count"}, 32'(ras_count), 32'(m_ras.size()));
  endtask

  // One clock cycle: drive, check combinational ras_hit, clock, check state.
  task automatic step(input string tag, input logic s, e, input logic [31:0] ep,
                      input logic r, input logic [31:0] rp, input logic pu,
                      input logic [31:0] pa, input logic po);
    stall = s; exc_req = e; exc_pc = ep; redirect = r; redirect_pc = rp;
    ras_push = pu; ras_push_addr = pa; ras_pop = po;
    #1;
    check({tag, ".ras_hit"}, 32'(ras_hit), 32'(model_hit(s, e, r, po)));
    @(posedge clk);
    model_update(s, e, ep, r, rp, pu, pa, po);
    #1;
    check_state(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, '0, 0, '0, 0, '0, 0);
  endtask

  task automatic push(input string tag, input logic [31:0] a);
    step(tag, 0, 0, '0, 0, '0, 1, a, 0);
  endtask

  task automatic pop(input string tag);
    step(tag, 0, 0, '0, 0, '0, 0, '0, 1);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    check_state({tag, ".async"});
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    stall = 0; exc_req = 0; redirect = 0; ras_push = 0; ras_pop = 0;
    exc_pc = '0; redirect_pc = '0; ras_push_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    @(negedge clk);
    reset = 1'b1;

    // Sequential run from reset vector.
    idle("seq1"); check("seq1.lit", pc, 32'h4);
    idle("seq2"); check("seq2.lit", pc, 32'h8);
    idle("seq3"); check("seq3.lit", pc, 32'hC);

    // Async reset mid-count takes effect before any clock edge.
    @(negedge clk);
    do_reset("midreset");
    check("midreset.lit", pc, 32'h0);

    // Stall hold then release.
    repeat (4) idle("to10");
    check("to10.lit", pc, 32'h10);
    repeat (3) step("stall", 1, 0, '0, 0, '0, 1, 32'hDEAD_0000, 1);
    check("stall.lit", pc, 32'h10);
    idle("unstall"); check("unstall.lit", pc, 32'h14);

    // Redirect overrides stall.
    step("redir20", 0, 0, '0, 1, 32'h20, 0, '0, 0);
    step("redir_stall", 1, 0, '0, 1, 32'h400, 1, 32'h1234, 1);
    check("redir_stall.lit", pc, 32'h400);

    // Push/pop pairs and empty pop.
    push("push100", 32'h100);
    push("push200", 32'h200);
    pop("pop1"); check("pop1.lit", pc, 32'h200);
    pop("pop2"); check("pop2.lit", pc, 32'h100);
    pop("pop3"); check("pop3.cnt", 32'(ras_count), 32'h0);

    // Overflow: oldest entry lost.
    push("ovA", 32'hA0); push("ovB", 32'hB0); push("ovC", 32'hC0);
    push("ovD", 32'hD0); push("ovE", 32'hE0);
    check("ov.cnt", 32'(ras_count), 32'd4);
    pop("ovp1"); check("ovp1.lit", pc, 32'hE0);
    pop("ovp2"); check("ovp2.lit", pc, 32'hD0);
    pop("ovp3"); check("ovp3.lit", pc, 32'hC0);
    pop("ovp4"); check("ovp4.lit", pc, 32'hB0);
    pop("ovp5"); check("ovp5.lit", pc, 32'hB4);

    // Exception wins over everything.
    push("pre_exc", 32'h123);
    step("exc", 1, 1, 32'h44, 1, 32'h300, 1, 32'h999, 1);
    check("exc.pc", pc, 32'h80);
    check("exc.epc", epc, 32'h44);
    check("exc.cnt", 32'(ras_count), 32'd1);

    // Address wrap.
    step("towrap", 0, 0, '0, 1, 32'hFFFF_FFFC, 0, '0, 0);
    idle("wrap"); check("wrap.lit", pc, 32'h0);

    // Simultaneous push+pop replaces top.
    @(negedge clk);
    do_reset("reset2");
    push("p50", 32'h50);
    step("pp60", 0, 0, '0, 0, '0, 1, 32'h60, 1);
    check("pp60.pc", pc, 32'h50);
    check("pp60.cnt", 32'(ras_count), 32'd1);
    pop("pop60"); check("pop60.lit", pc, 32'h60);
    // Push+pop on empty stack acts as push only.
    step("pp_empty", 0, 0, '0, 0, '0, 1, 32'h70, 1);
    check("pp_empty.cnt", 32'(ras_count), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        @(negedge clk);
        do_reset("rnd_reset");
      end else begin
        step("rnd",
             $urandom_range(0, 99) < 20,
             $urandom_range(0, 99) < 4,
             $urandom & 32'hFFFF_FFFC,
             $urandom_range(0, 99) < 8,
             $urandom & 32'hFFFF_FFFC,
             $urandom_range(0, 99) < 35,
             $urandom & 32'hFFFF_FFFC,
             $urandom_range(0, 99) < 35);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the IF stage; successor to the single-register PC.
- Selects the next fetch address by fixed priority: exception vector, resolved branch/jump redirect, stall hold, return-address-stack (RAS) prediction, sequential increment.
- Holds the exception PC (EPC) and a circular RAS for predicting call/return pairs.
- Feeds the instruction-memory address and the PC+INC value that travels down the pipeline.

Parameters:
- ADDR_WIDTH, 32, width of pc, all address ports and RAS entries.
- RESET_VECTOR, 32'h0000_0000, pc value while reset is asserted.
- EXC_VECTOR, 32'h0000_0080, pc target on exception.
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, number of RAS entries; power of two, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  1  hazard hold; pc and RAS keep their values.
- exc_req  in  1  exception request.
- exc_pc  in  ADDR_WIDTH  PC of the faulting instruction.
- redirect  in  1  branch/jump resolved taken (flush path).
- redirect_pc  in  ADDR_WIDTH  redirect target.
- ras_push  in  1  call decoded in ID; push the return address.
- ras_push_addr  in  ADDR_WIDTH  return address to push.
- ras_pop  in  1  return decoded in ID; predict from the top of stack.
- pc  out  ADDR_WIDTH  current fetch address.
- pc_inc  out  ADDR_WIDTH  pc + INC (combinational).
- epc  out  ADDR_WIDTH  last captured exception PC.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_hit  out  1  RAS prediction used this cycle.

Behaviour:
- Reset asserted (async, reset=0):
  - pc = RESET_VECTOR.
  - epc = 0.
  - RAS pointer = 0, ras_count = 0, all entries = 0.
  - Reset mid-operation discards all state immediately, without waiting for a clock edge.
- Next-pc priority, evaluated each rising edge:
  1. exc_req: pc <= EXC_VECTOR; epc <= exc_pc. Ignores stall. RAS is untouched.
  2. redirect: pc <= redirect_pc. Overrides stall. RAS push/pop are ignored this cycle.
  3. stall: pc holds. RAS push/pop are ignored.
  4. ras_pop with ras_count > 0: pc <= top entry; pointer decrements; count decrements.
  5. Otherwise: pc <= pc + INC, modulo 2^ADDR_WIDTH (wraps at the top of the address space).
- ras_hit: combinational. 1 exactly when priority 4 is taken in the current cycle.
- ras_pop with ras_count = 0: no prediction; sequential increment; count stays 0; ras_hit = 0.
- ras_push (at priority 4 or 5 only): write ras_push_addr at the pointer; pointer increments modulo RAS_DEPTH; count increments, saturating at RAS_DEPTH.
- Push when full: the oldest entry is overwritten; count stays RAS_DEPTH.
- Push and pop in the same cycle with count > 0:
  - pc <= old top.
  - Old top is replaced in place by ras_push_addr.
  - Pointer and count unchanged.
- Push and pop in the same cycle with count = 0: acts as a push only; sequential pc.
- epc changes only on exc_req.
- No RAS recovery on redirect. Mispredictions are corrected by the later EX redirect.
- Latency: one cycle from a control input to the new pc; pc_inc follows pc combinationally.

Test Plan:
- Reset then release, no controls: pc = 0, 4, 8, 12 on successive edges. Assert reset mid-count: pc = 0 immediately, before the next edge.
- pc = 0x10, stall=1 for 3 cycles then 0: pc holds 0x10, then goes to 0x14. pc = 0x20 with stall=1 and redirect=1 to 0x400: pc = 0x400 next cycle.
- Push 0x100, 0x200, then pop, pop, pop: pc = 0x200, then 0x100 (ras_hit=1 both times); third pop gives pc+4, ras_hit=0, ras_count=0.
- RAS_DEPTH=4: push 0xA0, 0xB0, 0xC0, 0xD0, 0xE0 → ras_count = 4. Five pops return 0xE0, 0xD0, 0xC0, 0xB0, then sequential (0xA0 was overwritten).
- Same cycle exc_req (exc_pc=0x44), redirect (0x300), stall and ras_pop: pc = 0x80, epc = 0x44, ras_count unchanged. pc = 0xFFFF_FFFC with no controls: pc wraps to 0x0.
- Push 0x50 then simultaneous push 0x60 + pop: pc = 0x50, ras_count = 1. Next pop: pc = 0x60.
